// File: rtl/ireg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ireg_pkg : shared defaults, address-width helper, operand source enum |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package ireg_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [1:0] {
    SRC_X  = 2'd0,
    SRC_M  = 2'd1,
    SRC_WB = 2'd2,
    SRC_RF = 2'd3
  } src_e;

  function automatic int aw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ireg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ireg_scoreboard : busy bits for long-latency results, per-port lookup |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module ireg_scoreboard
  import ireg_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = aw_f(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_v,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_clr_v,
  input  logic [AW-1:0]     i_clr_addr,
  input  logic [NRP*AW-1:0] i_rs_addr,
  input  logic [NRP-1:0]    i_rs_v,
  output logic [NRP-1:0]    o_hazard
);

  logic [NREG-1:0] r_busy;

  // Set beats clear on the same entry; register 0 is never tracked when hardwired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_set_v && (i_set_addr == AW'(i)) && !((ZERO_REG != 0) && (i == 0)))
          r_busy[i] <= 1'b1;
        else if (i_clr_v && (i_clr_addr == AW'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0] w_a;
    logic          w_zero;
    logic          w_busy_eff;
    logic          w_set_hit;

    assign w_a        = i_rs_addr[p*AW +: AW];
    assign w_zero     = (ZERO_REG != 0) && (w_a == '0);
    // A writeback landing this cycle is forwarded, so it retires the hazard.
    assign w_busy_eff = r_busy[w_a] && !(i_clr_v && (i_clr_addr == w_a));
    assign w_set_hit  = i_set_v && (i_set_addr == w_a);
    assign o_hazard[p] = i_rs_v[p] && !w_zero && (w_busy_eff || w_set_hit);
  end

endmodule
`default_nettype wire

// File: rtl/ireg_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ireg_sb : integer register file with X/M/WB bypass and scoreboard     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module ireg_sb
  import ireg_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw_f(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   rs_addr,
  input  logic [NRP-1:0]      rs_v,
  input  logic [AW-1:0]       rd,
  input  logic                rdx_v,
  input  logic                rdm_v,
  input  logic                lop_v,
  input  logic [XLEN-1:0]     rd_data_x,
  input  logic [XLEN-1:0]     rd_data_m,
  input  logic                wb_v,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic                hazard_x,
  output logic                stall_i
);

  logic [XLEN-1:0] r_rf [NREG];
  logic [AW-1:0]   r_rd_m;
  logic            r_rdm_v_m;
  logic            r_hazard_x;
  logic            r_stall_i;
  logic [NRP-1:0]  w_hx_hit;
  logic [NRP-1:0]  w_sb_hit;

  ireg_scoreboard #(
    .NREG     (NREG),
    .NRP      (NRP),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_v    (lop_v),
    .i_set_addr (rd),
    .i_clr_v    (wb_v),
    .i_clr_addr (wb_addr),
    .i_rs_addr  (rs_addr),
    .i_rs_v     (rs_v),
    .o_hazard   (w_sb_hit)
  );

  // Array is intentionally unreset; M and WB never target the same entry together.
  always_ff @(posedge clk) begin
    if (r_rdm_v_m && !((ZERO_REG != 0) && (r_rd_m == '0)))
      r_rf[r_rd_m] <= rd_data_m;
    if (wb_v && !((ZERO_REG != 0) && (wb_addr == '0)))
      r_rf[wb_addr] <= wb_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_m     <= '0;
      r_rdm_v_m  <= 1'b0;
      r_hazard_x <= 1'b0;
      r_stall_i  <= 1'b0;
    end else begin
      r_rd_m     <= rd;
      r_rdm_v_m  <= rdm_v;
      r_hazard_x <= |w_hx_hit;
      r_stall_i  <= (|w_hx_hit) | (|w_sb_hit);
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0]   w_a;
    logic            w_zero;
    src_e            w_src;
    logic [XLEN-1:0] w_val;
    logic [XLEN-1:0] r_data;

    assign w_a    = rs_addr[p*AW +: AW];
    assign w_zero = (ZERO_REG != 0) && (w_a == '0);

    always_comb begin
      w_src = SRC_RF;
      if (rdx_v && (rd == w_a))
        w_src = SRC_X;
      else if (r_rdm_v_m && (r_rd_m == w_a))
        w_src = SRC_M;
      else if (wb_v && (wb_addr == w_a))
        w_src = SRC_WB;
    end

    always_comb begin
      w_val = r_rf[w_a];
      case (w_src)
        SRC_X:   w_val = rd_data_x;
        SRC_M:   w_val = rd_data_m;
        SRC_WB:  w_val = wb_data;
        default: w_val = r_rf[w_a];
      endcase
      if (w_zero)
        w_val = '0;
    end

    // Load result arrives next cycle, so only a non-X producer causes the bubble.
    assign w_hx_hit[p] = rs_v[p] && !w_zero && (rd == w_a) && rdm_v && !rdx_v;

    // Idle ports hold their last operand so the output stays deterministic.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_data <= '0;
      else if (rs_v[p])
        r_data <= w_val;
    end

    assign rs_data[p*XLEN +: XLEN] = r_data;
  end

  assign hazard_x = r_hazard_x;
  assign stall_i  = r_stall_i;

endmodule
`default_nettype wire
